// File: rtl/fx3_stream_writer_if.sv
// Bundle of the sample-source, FX3 slave-FIFO and status signals of the
// StreamIN writer. The writer takes the master side; the ADC capture path
// and the FX3 pads (or a testbench) take the slave side.
`timescale 1ns/1ps
interface fx3_stream_writer_if #(
  parameter int DATA_W = 16
);
  logic              enable;
  logic              test_mode;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              flaga_d;
  logic              flagb_d;
  logic              slwr_;
  logic              pktend_;
  logic [31:0]       fdata;
  logic [15:0]       overflow_cnt;
  logic              busy;

  modport master (
    input  enable, test_mode, s_data, s_valid, flaga_d, flagb_d,
    output s_ready, slwr_, pktend_, fdata, overflow_cnt, busy
  );

  modport slave (
    output enable, test_mode, s_data, s_valid, flaga_d, flagb_d,
    input  s_ready, slwr_, pktend_, fdata, overflow_cnt, busy
  );
endinterface

// File: rtl/fx3_stream_writer.sv
// FX3 slave-FIFO StreamIN writer. Buffers ADC samples (or an internal 32-bit
// test counter) in a small FIFO and writes them to the FX3 under FLAGA/FLAGB
// flow control. Partial DMA buffers are committed with a zero-length PKTEND
// once streaming stops; samples that arrive while the FIFO is full are
// dropped and counted.
`timescale 1ns/1ps
module fx3_stream_writer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int BUF_WORDS  = 1024,
  parameter int POST_WM    = 1
) (
  input  logic                   clk_100,
  input  logic                   reset_,
  fx3_stream_writer_if.master    bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BUF_WORDS) + 1;
  localparam int PW = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FLAGB,
    S_WRITE,
    S_WR_DELAY,
    S_FLUSH
  } state_t;

  // FIFO storage and pointers (one extra pointer bit separates full from empty)
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  logic [31:0]   r_test_cnt;
  logic [15:0]   r_ovf_cnt;
  logic [BW-1:0] r_buf_cnt;
  logic [PW-1:0] r_post;
  state_t        r_state;

  logic          r_slwr_n;
  logic          r_pktend_n;
  logic [31:0]   r_fdata;

  logic [DATA_W-1:0] w_s_data;
  logic [31:0]   w_src;
  logic          w_empty;
  logic          w_full;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  state_t        w_state_nxt;
  logic [PW-1:0] w_post_nxt;

  assign w_s_data   = bus.s_data;
  assign w_src      = bus.test_mode ? r_test_cnt : 32'(w_s_data);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // The test counter pushes every cycle; the ADC path only on its strobe.
  assign w_push_req = bus.enable && (bus.test_mode || bus.s_valid);
  // Full is judged before any same-cycle pop, so a pop never makes room.
  assign w_push     = w_push_req && !w_full;

  // Sample storage: written on accepted pushes only
  // NOTE: the FIFO array has no reset; the pointers alone define its contents,
  // and a resettable array would turn the RAM into thousands of flops.
  always_ff @(posedge clk_100) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_src;
  end

  // FIFO pointers
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Internal test pattern: held at 0 while disabled, advances per accepted push
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_)                          r_test_cnt <= '0;
    else if (!bus.enable)                 r_test_cnt <= '0;
    else if (w_push && bus.test_mode)     r_test_cnt <= r_test_cnt + 32'd1;
  end

  // Dropped-sample counter, saturating, cleared only by reset
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_)
      r_ovf_cnt <= '0;
    else if (w_push_req && w_full && (r_ovf_cnt != 16'hFFFF))
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end

  // FSM state and post-watermark write allowance
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      r_state <= S_IDLE;
      r_post  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_post  <= w_post_nxt;
    end
  end

  // FSM next state and pop decision
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_post_nxt  = r_post;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.flaga_d && !w_empty)
          w_state_nxt = S_WAIT_FLAGB;
        else if (!bus.enable && w_empty && (r_buf_cnt != '0))
          w_state_nxt = S_FLUSH;
      end
      S_WAIT_FLAGB: begin
        if (bus.flagb_d) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        // The pop in the cycle FLAGB is first seen low still goes out; the
        // FX3 watermark leaves room for it plus POST_WM more.
        w_pop = !w_empty;
        if (!bus.flagb_d) begin
          w_state_nxt = S_WR_DELAY;
          w_post_nxt  = PW'(POST_WM);
        end else if (w_empty && !bus.enable) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_DELAY: begin
        if ((r_post == '0) || w_empty) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_pop      = 1'b1;
          w_post_nxt = r_post - 1'b1;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered FX3 pad outputs: a pop appears on the bus one cycle later
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      r_slwr_n   <= 1'b1;
      r_pktend_n <= 1'b1;
      r_fdata    <= '0;
    end else begin
      r_slwr_n   <= !w_pop;
      // FLUSH never pops, so PKTEND can never coincide with a write strobe.
      r_pktend_n <= (r_state != S_FLUSH);
      if (w_pop) r_fdata <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  // Words written into the current FX3 DMA buffer; FX3 auto-commits full ones
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_)
      r_buf_cnt <= '0;
    else if (r_state == S_FLUSH)
      r_buf_cnt <= '0;
    else if (!r_slwr_n)
      r_buf_cnt <= (r_buf_cnt == BW'(BUF_WORDS - 1)) ? '0 : r_buf_cnt + 1'b1;
  end

  assign bus.slwr_        = r_slwr_n;
  assign bus.pktend_      = r_pktend_n;
  assign bus.fdata        = r_fdata;
  assign bus.overflow_cnt = r_ovf_cnt;
  assign bus.s_ready      = !w_full;
  assign bus.busy         = (r_state != S_IDLE) || !w_empty;

endmodule

// File: doc/fx3_stream_writer.md
# fx3_stream_writer

Parametrised StreamIN writer for the FX3 slave-FIFO interface. It buffers ADC samples (or an internal test counter) in an on-chip FIFO and drives slwr_, pktend_ and the 32-bit FX3 data bus under flaga_d/flagb_d flow control. It flushes short packets with PKTEND when streaming stops mid-buffer, and it counts dropped samples. It sits between the ADC capture path and the FX3 GPIF pads, and supersedes the fixed test-counter StreamIN writer.

## Interface
- DATA_W, 16: sample width. Must be ≤ 32. Zero-extended onto fdata.
- FIFO_DEPTH, 64: sample FIFO depth. Must be a power of 2, ≥ 4.
- BUF_WORDS, 1024: words per FX3 DMA buffer. Used for PKTEND decisions.
- POST_WM, 1: writes still allowed after flagb_d falls, covering the FX3 watermark latency. Range 0–3.
- clk_100  in  1  100 MHz interface clock.
- reset_  in  1  Asynchronous, active-low reset.
- enable  in  1  Streaming enable. Level-sensitive.
- test_mode  in  1  1 = source is the internal 32-bit counter, 0 = source is s_data.
- s_data  in  DATA_W  ADC sample.
- s_valid  in  1  Sample strobe. The ADC cannot stall.
- s_ready  out  1  FIFO not full. Informational.
- flaga_d  in  1  Registered FX3 FLAGA. 1 = thread ready.
- flagb_d  in  1  Registered FX3 FLAGB. 1 = above watermark.
- slwr_  out  1  FX3 write strobe. Active low, registered.
- pktend_  out  1  FX3 packet end. Active low, registered.
- fdata  out  32  FX3 data bus. Registered.
- overflow_cnt  out  16  Dropped samples. Saturates at 16'hFFFF.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

## Operation
**Source selection**
- When test_mode = 1, the source word is a 32-bit counter.
  - It increments once per accepted push.
  - It clears to 0 while enable = 0.
  - s_valid is ignored; a push is attempted every cycle.
- When test_mode = 0, the source word is s_data, pushed when s_valid = 1.

**FIFO push and overflow**
- A push is accepted only when enable = 1 and the FIFO is not full.
- "Full" is evaluated on the pre-pop count. A same-cycle pop does not make room.
- A push attempted while full is dropped and increments overflow_cnt (saturating).
- overflow_cnt clears only on reset.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.

**FSM states**
- IDLE
  - Go to WAIT_FLAGB when flaga_d = 1 and the FIFO is non-empty.
  - Go to FLUSH when enable = 0, the FIFO is empty and buf_cnt ≠ 0.
- WAIT_FLAGB
  - Go to WRITE when flagb_d = 1.
- WRITE
  - Each cycle with FIFO non-empty: pop one word. Next cycle, slwr_ = 0 and fdata = that word.
  - FIFO empty: no pop, and slwr_ = 1 next cycle. Go to IDLE when the FIFO is empty and enable = 0.
  - flagb_d = 0: go to WR_DELAY with post = POST_WM.
- WR_DELAY
  - Pop while post ≠ 0 and the FIFO is non-empty; decrement post on each pop.
  - Go to IDLE when post = 0 or the FIFO is empty.
- FLUSH
  - Drive pktend_ = 0 for exactly one cycle with slwr_ = 1 (zero-data PKTEND commits the partial buffer).
  - Clear buf_cnt, then go to IDLE.

**Buffer word count**
- buf_cnt (log2(BUF_WORDS)+1 bits) increments on every slwr_ = 0 cycle.
- It wraps to 0 on reaching BUF_WORDS. The buffer is auto-committed by FX3.

**Enable mid-stream**
- When enable falls during WRITE, already-buffered words still drain under flag control.
- Then FLUSH runs if buf_cnt ≠ 0. No data is discarded.

## Timing
- Reset values:
  - slwr_ = 1, pktend_ = 1, fdata = 0
  - overflow_cnt = 0, busy = 0, s_ready = 1
  - FSM = IDLE, FIFO empty, buf_cnt = 0, test counter = 0
- Latency:
  - Input to FIFO: 1 cycle.
  - Pop to slwr_/fdata: 1 cycle.
  - Minimum s_valid to first slwr_ = 0: 4 cycles (push, IDLE→WAIT_FLAGB, →WRITE/pop, output).
- slwr_ = 0 and pktend_ = 0 never occur in the same cycle.
- Maximum writes after the flagb_d falling sample: 1 + POST_WM. That count includes the pop in the cycle flagb_d = 0 is sampled; the FSM leaves WRITE in that cycle.
- flaga_d falling outside IDLE is ignored. flagb_d governs writes.
- Reset asserted mid-burst: all outputs return to their reset values asynchronously and FIFO contents are lost. No PKTEND is issued.

## Test plan
- **Test-counter burst.** Reset, test_mode = 1, enable = 1, flaga_d = flagb_d = 1 → fdata = 0, 1, 2, … on consecutive slwr_ = 0 cycles, with no gaps after the first word.
- **Watermark.** POST_WM = 1, drop flagb_d during continuous streaming → exactly 2 further slwr_ = 0 cycles, FSM back to IDLE, and the word sequence resumes without loss when flagb_d returns.
- **Overflow.** flaga_d = 0 with test_mode = 0 and s_valid = 1 for FIFO_DEPTH + 10 cycles → s_ready = 0 after 64 pushes, overflow_cnt = 10, and the first 64 samples are later emitted intact.
- **Short-packet flush.** Stream 100 words, then drop enable → all 100 words written, then a single pktend_ = 0 pulse with slwr_ = 1, and buf_cnt = 0.
- **Exact-buffer stop.** Stream exactly BUF_WORDS words, then drop enable → no pktend_ pulse.
- **Async reset mid-WRITE.** Assert reset_ during WRITE → slwr_ = 1, pktend_ = 1, fdata = 0 immediately; after release, busy = 0 and overflow_cnt = 0.
